// File: rtl/user_module_debounce_counter_if.sv
// Pin bundle for the debounced BCD up/down counter: eight inputs (clock, reset,
// buttons, load value) and eight outputs (segments plus wrap pulse).
interface user_module_debounce_counter_if;
   logic [7:0] io_in;
   logic [7:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/user_module_debounce_counter.sv
// Debounced single-digit BCD up/down/load counter with seven-segment output.
// io_in[0] is the clock, io_in[1] the async active-low reset; io_in[7:2] are
// synchronized, debounced, then edge-detected into one-shot events.
module user_module_debounce_counter #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   user_module_debounce_counter_if.slave bus
);

   localparam int unsigned NB    = 6;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DIG_W = 4;

   // Bit positions within the synchronized/debounced vector
   localparam int unsigned B_UP   = 0;
   localparam int unsigned B_DOWN = 1;
   localparam int unsigned B_LOAD = 2;

   logic clk;
   logic rst_n;
   assign clk   = bus.io_in[0];
   assign rst_n = bus.io_in[1];

   logic [NB-1:0]    sync1;
   logic [NB-1:0]    sync2;
   logic [NB-1:0]    stable;
   logic [NB-1:0]    stable_nxt;
   logic [CNT_W-1:0] cnt     [NB];
   logic [CNT_W-1:0] cnt_nxt [NB];
   logic [2:0]       stable_d;

   logic             evt_up;
   logic             evt_down;
   logic             evt_load;

   logic [DIG_W-1:0] digit;
   logic [DIG_W-1:0] digit_nxt;
   logic             wrap;
   logic             wrap_nxt;
   logic [6:0]       seg;

   // Two-flop synchronizer for the asynchronous button and load-value pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.io_in[7:2];
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing clocks
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < NB; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= '0;
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable <= stable_nxt;
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   // Delayed copy of the debounced buttons for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_d <= '0;
      end else begin
         stable_d <= stable[2:0];
      end
   end

   assign evt_up   = stable[B_UP]   & ~stable_d[B_UP];
   assign evt_down = stable[B_DOWN] & ~stable_d[B_DOWN];
   assign evt_load = stable[B_LOAD] & ~stable_d[B_LOAD];

   // Next digit: load beats up/down, simultaneous up+down cancels, wraps flag a pulse
   always_comb begin
      digit_nxt = digit;
      wrap_nxt  = 1'b0;
      if (evt_load) begin
         digit_nxt = {1'b0, stable[5:3]};
      end else if (evt_up && !evt_down) begin
         if (digit == DIG_W'(9)) begin
            digit_nxt = '0;
            wrap_nxt  = 1'b1;
         end else begin
            digit_nxt = digit + DIG_W'(1);
         end
      end else if (evt_down && !evt_up) begin
         if (digit == '0) begin
            digit_nxt = DIG_W'(9);
            wrap_nxt  = 1'b1;
         end else begin
            digit_nxt = digit - DIG_W'(1);
         end
      end
   end

   // Digit and wrap-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
         wrap  <= 1'b0;
      end else begin
         digit <= digit_nxt;
         wrap  <= wrap_nxt;
      end
   end

   // Seven-segment decode of the digit register (bit0=a .. bit6=g)
   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end

   assign bus.io_out = {wrap, seg};

endmodule

// File: tb/tb_user_module_debounce_counter.sv
// Testbench for user_module_debounce_counter: directed vector table, hand-built
// corner-case sequences, and randomized button activity against a reference model.
module tb_user_module_debounce_counter;

   localparam int unsigned N = 4;

   localparam logic [5:0] UP = 6'b000_001;
   localparam logic [5:0] DN = 6'b000_010;
   localparam logic [5:0] LD = 6'b000_100;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [5:0] btn   = '0;

   user_module_debounce_counter_if bus ();
   assign bus.io_in = {btn, rst_n, clk};

   user_module_debounce_counter #(.DEBOUNCE_CYCLES(N)) dut (.bus(bus));

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [6:0] seg_tab [10];

   // Reference model: raw samples per edge, debounced levels, digit, wrap
   logic [5:0] hist [$];
   logic [5:0] m_stable   = '0;
   logic [5:0] m_stable_d = '0;
   logic [3:0] m_digit    = '0;
   logic       m_wrap     = 1'b0;

   typedef struct {
      logic [5:0] btn;
      int         hold;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t tbl [15];

   function automatic logic [7:0] m_out();
      return {m_wrap, seg_tab[m_digit]};
   endfunction

   // One clock edge of the model: events from the previous debounced levels, then a
   // level is accepted once the synchronized input (two edges old) has differed from
   // it on N consecutive edges.
   task automatic model_step();
      logic up_e, dn_e, ld_e, flip, v;
      int   n, idx;
      if (!rst_n) begin
         hist.delete();
         m_stable   = '0;
         m_stable_d = '0;
         m_digit    = '0;
         m_wrap     = 1'b0;
         return;
      end
      up_e   = m_stable[0] & ~m_stable_d[0];
      dn_e   = m_stable[1] & ~m_stable_d[1];
      ld_e   = m_stable[2] & ~m_stable_d[2];
      m_wrap = 1'b0;
      if (ld_e) begin
         m_digit = {1'b0, m_stable[5:3]};
      end else if (up_e && !dn_e) begin
         if (m_digit == 4'd9) begin
            m_digit = 4'd0;
            m_wrap  = 1'b1;
         end else begin
            m_digit = m_digit + 4'd1;
         end
      end else if (dn_e && !up_e) begin
         if (m_digit == 4'd0) begin
            m_digit = 4'd9;
            m_wrap  = 1'b1;
         end else begin
            m_digit = m_digit - 4'd1;
         end
      end
      m_stable_d = m_stable;
      hist.push_back(btn);
      n = hist.size();
      for (int i = 0; i < 6; i++) begin
         flip = 1'b1;
         for (int j = 0; j < int'(N); j++) begin
            idx = n - 3 - j;
            v   = (idx >= 0) ? hist[idx][i] : 1'b0;
            if (v == m_stable[i]) flip = 1'b0;
         end
         if (flip) m_stable[i] = ~m_stable[i];
      end
      if (hist.size() > 32) void'(hist.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
   endtask

   task automatic check_cnt(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn   = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Hold a pattern, release it, and report wrap-pulse cycles and the value seen while pulsing
   task automatic press(input logic [5:0] v, input int hold, input int rel,
                        output int pulses, output logic [7:0] pv);
      pulses = 0;
      pv     = '0;
      btn    = v;
      repeat (hold) begin
         tick();
         if (bus.io_out[7]) begin pulses++; pv = bus.io_out; end
      end
      btn = '0;
      repeat (rel) begin
         tick();
         if (bus.io_out[7]) begin pulses++; pv = bus.io_out; end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         p;
      int         hold_left;
      int         rst_left;
      logic [7:0] pv;

      seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
      seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
      seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

      tbl[0]  = '{6'b0,                 3,  8'h3F, "idle"};
      tbl[1]  = '{UP,                   3,  8'h3F, "glitch3_hold"};
      tbl[2]  = '{6'b0,                 10, 8'h3F, "glitch3_after"};
      tbl[3]  = '{UP,                   20, 8'h06, "up_hold20"};
      tbl[4]  = '{6'b0,                 10, 8'h06, "up_release"};
      tbl[5]  = '{DN,                   10, 8'h3F, "down_to_0"};
      tbl[6]  = '{6'b0,                 10, 8'h3F, "down_release"};
      tbl[7]  = '{DN,                   10, 8'h6F, "down_wrap_9"};
      tbl[8]  = '{6'b0,                 10, 8'h6F, "wrap_release"};
      tbl[9]  = '{{3'd5, 3'b101},       10, 8'h6D, "load5_with_up"};
      tbl[10] = '{6'b0,                 10, 8'h6D, "load_release"};
      tbl[11] = '{UP | DN,              10, 8'h6D, "up_down_same"};
      tbl[12] = '{6'b0,                 10, 8'h6D, "updown_release"};
      tbl[13] = '{UP,                   10, 8'h7D, "up_to_6"};
      tbl[14] = '{6'b0,                 10, 8'h7D, "final_release"};

      // Reset asserted between edges drives the output immediately
      #2 rst_n = 1'b0;
      #1 check("reset_out", bus.io_out, 8'h3F);
      tick();
      tick();
      rst_n = 1'b1;

      // Directed vector table
      foreach (tbl[k]) begin
         btn = tbl[k].btn;
         repeat (tbl[k].hold) tick();
         check(tbl[k].name, bus.io_out, tbl[k].exp);
      end

      // Latency: accepted on edge 7, not edge 6, then held
      do_reset();
      btn = UP;
      repeat (6) tick();
      check("latency_edge6", bus.io_out, 8'h3F);
      tick();
      check("latency_edge7", bus.io_out, 8'h06);
      repeat (13) tick();
      check("held_one_event", bus.io_out, 8'h06);
      btn = '0;
      repeat (10) tick();

      // Ten up presses from 0 step through 1..9 then wrap to 0 with one pulse
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         press(UP, 8, 8, p, pv);
         if (k < 10) begin
            check("up_step", bus.io_out, {1'b0, seg_tab[k]});
         end else begin
            check_cnt("up_wrap_pulses", p, 1);
            check("up_wrap_pulse_val", pv, 8'hBF);
            check("up_wrap_after", bus.io_out, 8'h3F);
         end
      end

      // Down press at 0 wraps to 9 with one pulse
      do_reset();
      press(DN, 8, 8, p, pv);
      check_cnt("down_wrap_pulses", p, 1);
      check("down_wrap_pulse_val", pv, 8'hEF);
      check("down_wrap_after", bus.io_out, 8'h6F);

      // Load of 0 at digit 9 gives no wrap pulse
      press({3'd0, LD[2:0]}, 8, 8, p, pv);
      check_cnt("load0_no_pulse", p, 0);
      check("load0_after", bus.io_out, 8'h3F);

      // Load 7, then async reset between edges
      press({3'd7, LD[2:0]}, 8, 8, p, pv);
      check("load7", bus.io_out, 8'h07);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_from_7", bus.io_out, 8'h3F);
      tick();
      tick();
      rst_n = 1'b1;

      // Reset mid-debounce discards partial count; held button counts once after release
      do_reset();
      btn = UP;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      tick();
      check("midpress_in_reset", bus.io_out, 8'h3F);
      rst_n = 1'b1;
      repeat (6) tick();
      check("midpress_edge6", bus.io_out, 8'h3F);
      tick();
      check("midpress_edge7", bus.io_out, 8'h06);
      repeat (10) tick();
      check("midpress_held", bus.io_out, 8'h06);
      btn = '0;
      repeat (10) tick();

      // Randomized buttons, hold lengths and occasional resets against the model
      do_reset();
      hold_left = 0;
      rst_left  = 0;
      for (int it = 0; it < 4000; it++) begin
         if (hold_left == 0) begin
            btn       = 6'($urandom);
            hold_left = $urandom_range(1, 12);
         end
         hold_left--;
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n    = 1'b0;
            rst_left = $urandom_range(1, 3);
         end
         tick();
         check("random", bus.io_out, m_out());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
